// File: rtl/image_line_streamer.sv
// image_line_streamer: streams an 8-bit image row by row from a synchronous
// frame memory to the line-buffer controller, gated by row credits.
//
// Ports:
//   i_clk, i_rst_n      clock (rising edge), async active-low reset
//   i_start             frame start pulse (ignored while busy or in FIN)
//   i_base_addr         frame base address, latched on accepted start
//   i_intr              row-consumed pulse, +1 credit per cycle high
//   o_mem_rd_en         memory read strobe
//   o_mem_addr          memory read address
//   i_mem_rd_data       memory read data, 1 cycle after o_mem_rd_en
//   o_pixel_data        pixel to controller (0 during pad rows)
//   o_pixel_data_valid  pixel qualifier
//   o_busy              frame in progress
//   o_done              1-cycle pulse after the last pad pixel
module image_line_streamer #(
    parameter int IMG_WIDTH     = 512,
    parameter int IMG_HEIGHT    = 512,
    parameter int PRELOAD_LINES = 4,
    parameter int PAD_LINES     = 2,
    parameter int ADDR_W        = 18
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic              i_intr,
    output logic              o_mem_rd_en,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic [7:0]        i_mem_rd_data,
    output logic [7:0]        o_pixel_data,
    output logic              o_pixel_data_valid,
    output logic              o_busy,
    output logic              o_done
);

    localparam int ROWS  = IMG_HEIGHT + PAD_LINES;
    localparam int ROW_W = $clog2(ROWS + 1);
    localparam int COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;

    localparam logic [ROW_W-1:0] ROW_IMG  = ROW_W'(IMG_HEIGHT);
    localparam logic [ROW_W-1:0] ROW_END  = ROW_W'(ROWS);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [2:0]       CRED_INI = 3'(PRELOAD_LINES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_SEND,
        S_PAD,
        S_FIN
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [2:0]        credits_q;
    logic [ROW_W-1:0]  row_q;
    logic [COL_W-1:0]  col_q;
    logic [ADDR_W-1:0] addr_q;
    logic              valid_q;
    logic              pad_q;

    logic issue;
    logic start_acc;
    logic intr_acc;
    logic consume;

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (i_start) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (row_q == ROW_END) begin
                    state_d = S_FIN;
                end else if (credits_q != 3'd0) begin
                    state_d = (row_q < ROW_IMG) ? S_SEND : S_PAD;
                end
            end
            S_SEND, S_PAD: begin
                if (col_q == COL_LAST) state_d = S_WAIT;
            end
            S_FIN: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        issue       = 1'b0;
        o_mem_rd_en = 1'b0;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        unique case (state_q)
            S_WAIT: o_busy = 1'b1;
            S_SEND: begin
                issue       = 1'b1;
                o_mem_rd_en = 1'b1;
                o_busy      = 1'b1;
            end
            S_PAD: begin
                issue  = 1'b1;
                o_busy = 1'b1;
            end
            S_FIN:  o_done = 1'b1;
            default: ;
        endcase
    end

    assign start_acc = (state_q == S_IDLE) && i_start;
    assign intr_acc  = (state_q != S_IDLE) && i_intr;
    assign consume   = (state_q == S_WAIT) &&
                       ((state_d == S_SEND) || (state_d == S_PAD));

    // Counters, address and output pipe
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            credits_q <= '0;
            row_q     <= '0;
            col_q     <= '0;
            addr_q    <= '0;
            valid_q   <= 1'b0;
            pad_q     <= 1'b0;
        end else begin
            valid_q <= issue;
            pad_q   <= (state_q == S_PAD);

            // A grant and a consume in the same cycle cancel out
            if (start_acc) begin
                credits_q <= CRED_INI;
            end else if (intr_acc && !consume) begin
                if (credits_q != 3'd7) credits_q <= credits_q + 3'd1;
            end else if (consume && !intr_acc) begin
                credits_q <= credits_q - 3'd1;
            end

            if (start_acc) begin
                addr_q <= i_base_addr;
                row_q  <= '0;
                col_q  <= '0;
            end

            // Rows are contiguous in memory, so the address just
            // keeps counting across row boundaries.
            if (state_q == S_SEND) begin
                addr_q <= addr_q + ADDR_W'(1);
            end

            if (issue) begin
                if (col_q == COL_LAST) begin
                    col_q <= '0;
                    row_q <= row_q + ROW_W'(1);
                end else begin
                    col_q <= col_q + COL_W'(1);
                end
            end
        end
    end

    assign o_mem_addr         = addr_q;
    assign o_pixel_data_valid = valid_q;
    assign o_pixel_data       = (valid_q && !pad_q) ? i_mem_rd_data : 8'h00;

endmodule
